serial_subtractor: RTL and testbench

- Parametrised bit-serial subtractor. Computes a WIDTH-bit difference one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- It is the sequential, multi-bit successor to the team's single-bit half/full subtractor cells.
- Intended for area-constrained datapaths where latency of WIDTH+1 cycles is acceptable.
- Uses a start/busy/done handshake. Results are flagged with borrow, signed overflow and zero.

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and a registered borrow,
// LSB first, with a start/busy/done handshake and borrow/overflow/zero flags.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] m_sh, s_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             br, m_msb, s_msb;
    logic             d, br_next, accept;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        d        = m_sh[0] ^ s_sh[0] ^ br;
        br_next  = (~m_sh[0] & s_sh[0]) | (~(m_sh[0] ^ s_sh[0]) & br);
        // new bit enters at the MSB; written as shifts so WIDTH=1 needs no slice
        res_next = (res_sh >> 1) | (WIDTH'(d) << (WIDTH - 1));
        accept   = start && (state == IDLE || state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m_sh       <= '0;
            s_sh       <= '0;
            res_sh     <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            m_msb      <= 1'b0;
            s_msb      <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (accept) begin
            m_sh   <= mode ? b : a;
            s_sh   <= mode ? a : b;
            m_msb  <= mode ? b[WIDTH-1] : a[WIDTH-1];
            s_msb  <= mode ? a[WIDTH-1] : b[WIDTH-1];
            br     <= borrow_in;
            cnt    <= '0;
            res_sh <= '0;
            state  <= SHIFT;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    m_sh   <= m_sh >> 1;
                    s_sh   <= s_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= res_next;
                        borrow_out <= br_next;
                        overflow   <= (m_msb != s_msb) && (d != m_msb);
                        zero       <= (res_next == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH 8, 1 and 32 against an arithmetic reference.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  start = '0;
    logic        mode = 1'b0, bin = 1'b0;
    logic [63:0] a64 = '0, b64 = '0;
    logic [7:0]  diff8;
    logic [0:0]  diff1;
    logic [31:0] diff32;
    logic [2:0]  bo, ov, zr, busy, done;
    int tests = 0, fails = 0;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode), .a(a64[7:0]), .b(b64[7:0]),
        .borrow_in(bin), .diff(diff8), .borrow_out(bo[0]), .overflow(ov[0]), .zero(zr[0]),
        .busy(busy[0]), .done(done[0]));
    serial_subtractor #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode), .a(a64[0:0]), .b(b64[0:0]),
        .borrow_in(bin), .diff(diff1), .borrow_out(bo[1]), .overflow(ov[1]), .zero(zr[1]),
        .busy(busy[1]), .done(done[1]));
    serial_subtractor #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode), .a(a64[31:0]), .b(b64[31:0]),
        .borrow_in(bin), .diff(diff32), .borrow_out(bo[2]), .overflow(ov[2]), .zero(zr[2]),
        .busy(busy[2]), .done(done[2]));

    function automatic int wof(int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 1 : 32;
    endfunction

    function automatic logic [63:0] dget(int sel);
        return (sel == 0) ? 64'(diff8) : (sel == 1) ? 64'(diff1) : 64'(diff32);
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction and signed range test.
    task automatic ref_model(int w, logic [63:0] av, logic [63:0] bv, logic md, logic bi,
                             output logic [63:0] ed, output logic eb, output logic eo,
                             output logic ez);
        longint mask, half, mu, su, ms, ss, sd;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        mu   = md ? (longint'(bv) & mask) : (longint'(av) & mask);
        su   = md ? (longint'(av) & mask) : (longint'(bv) & mask);
        ed   = 64'((mu - su - longint'(bi)) & mask);
        eb   = mu < su + longint'(bi);
        ms   = (mu >= half) ? mu - (mask + 1) : mu;
        ss   = (su >= half) ? su - (mask + 1) : su;
        sd   = ms - ss - longint'(bi);
        eo   = (sd >= half) || (sd < -half);
        ez   = (ed == 64'd0);
    endtask

    // One operation: poke>0 pulses start (with changed operands) in that SHIFT cycle.
    task automatic run_op(int sel, logic [63:0] av, logic [63:0] bv, logic md, logic bi,
                          int poke, string tag);
        int w, bcnt;
        bit hold;
        logic [63:0] ed, prevd;
        logic eb, eo, ez;
        w = wof(sel);
        ref_model(w, av, bv, md, bi, ed, eb, eo, ez);
        @(negedge clk);
        prevd = dget(sel);
        a64 = av; b64 = bv; mode = md; bin = bi; start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        mode = 1'($urandom); bin = 1'($urandom);
        bcnt = 0; hold = 1'b1;
        for (int c = 1; c <= w; c++) begin
            if (busy[sel] && !done[sel]) bcnt++;
            if (dget(sel) !== prevd) hold = 1'b0;
            if (c == poke) begin
                start[sel] = 1'b1;
                a64 = ~av;
            end
            @(negedge clk);
            start[sel] = 1'b0;
        end
        chk({tag, "/busy_len"}, 64'(bcnt), 64'(w));
        chk({tag, "/hold"}, 64'(hold), 64'd1);
        chk({tag, "/done"}, {62'd0, done[sel], busy[sel]}, 64'd2);
        chk({tag, "/diff"}, dget(sel), ed);
        chk({tag, "/flags"}, {61'd0, bo[sel], ov[sel], zr[sel]}, {61'd0, eb, eo, ez});
        @(negedge clk);
        chk({tag, "/done_pulse"}, 64'(done[sel]), 64'd0);
    endtask

    initial begin
        int gap;
        bit seen;
        logic [63:0] ed;
        logic eb, eo, ez;

        #1;
        chk("rst/u8", {diff8, bo[0], ov[0], zr[0], busy[0], done[0]}, 64'd0);
        chk("rst/u1", {diff1, bo[1], ov[1], zr[1], busy[1], done[1]}, 64'd0);
        chk("rst/u32", {diff32, bo[2], ov[2], zr[2], busy[2], done[2]}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 64'h05, 64'h03, 1'b0, 1'b0, 0, "w8_05m03");
        chk("w8_05m03/const", 64'(diff8), 64'h02);
        run_op(0, 64'h03, 64'h05, 1'b0, 1'b0, 0, "w8_03m05");
        chk("w8_03m05/const", {55'd0, diff8, bo[0]}, {55'd0, 8'hFE, 1'b1});
        run_op(0, 64'h03, 64'h05, 1'b1, 1'b0, 0, "w8_mode1");
        run_op(0, 64'h80, 64'h01, 1'b0, 1'b0, 0, "w8_ovf");
        chk("w8_ovf/const", {55'd0, diff8, ov[0]}, {55'd0, 8'h7F, 1'b1});
        run_op(0, 64'h00, 64'h00, 1'b0, 1'b1, 0, "w8_bin");
        run_op(0, 64'h2A, 64'h2A, 1'b0, 1'b0, 0, "w8_zero");
        run_op(0, 64'h91, 64'h37, 1'b0, 1'b0, 3, "w8_poke");

        // back-to-back: start held during the DONE cycle
        @(negedge clk);
        a64 = 64'h10; b64 = 64'h01; mode = 1'b0; bin = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        gap = 0;
        while (!done[0] && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b/first_done", 64'(done[0]), 64'd1);
        chk("b2b/first_diff", 64'(diff8), 64'h0F);
        a64 = 64'h44; b64 = 64'h65; start[0] = 1'b1;
        ref_model(8, 64'h44, 64'h65, 1'b0, 1'b0, ed, eb, eo, ez);
        @(negedge clk);
        start[0] = 1'b0;
        gap = 1;
        while (!done[0] && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b/gap", 64'(gap), 64'd9);
        chk("b2b/diff", 64'(diff8), ed);
        chk("b2b/borrow", 64'(bo[0]), 64'(eb));

        // asynchronous reset in the 4th SHIFT cycle
        @(negedge clk);
        a64 = 64'hC3; b64 = 64'h12; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid/outputs", {diff8, bo[0], ov[0], zr[0], busy[0], done[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(negedge clk); if (done[0] || busy[0]) seen = 1'b1; end
        chk("rst_mid/no_done", 64'(seen), 64'd0);
        run_op(0, 64'hC3, 64'h12, 1'b0, 1'b0, 0, "rst_mid/after");

        for (int i = 0; i < 8; i++)
            run_op(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                   1'($urandom), 0, "w8_rand");
        for (int i = 0; i < 8; i++)
            run_op(1, 64'(i[0]), 64'(i[1]), 1'b0, i[2], 0, "w1_exh");
        run_op(1, 64'd0, 64'd1, 1'b1, 1'b0, 0, "w1_mode1");
        for (int i = 0; i < 8; i++)
            run_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                   1'($urandom), (i == 3) ? 10 : 0, "w32_rand");
        run_op(2, 64'h8000_0000, 64'h1, 1'b0, 1'b0, 0, "w32_ovf");
        run_op(2, 64'h1234_5678, 64'h1234_5678, 1'b1, 1'b0, 0, "w32_zero");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
